// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 derived datapath blocks: opcode encoding
// for the in-place register operations.
package sap1_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_SHL  = 2'b11;

endpackage : sap1_pkg

// File: rtl/reg_op_alu.sv
// Combinational next-value logic for one register: given the current value,
// the opcode and the input data, produce the new register value and the
// carry / borrow / shift-out bit.
module reg_op_alu
  import sap1_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] reg_in,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] entrada,
  output logic [WIDTH-1:0] reg_next,
  output logic             cout_next
);

  // Select the operation result and its carry-out bit.
  always_comb begin
    reg_next  = reg_in;
    cout_next = 1'b0;
    case (op)
      OP_LOAD: begin
        reg_next  = entrada;
        cout_next = 1'b0;
      end
      OP_INC: begin
        {cout_next, reg_next} = {1'b0, reg_in} + {{WIDTH{1'b0}}, 1'b1};
      end
      OP_DEC: begin
        reg_next  = reg_in - {{(WIDTH-1){1'b0}}, 1'b1};
        cout_next = (reg_in == {WIDTH{1'b0}});
      end
      OP_SHL: begin
        reg_next  = {reg_in[WIDTH-2:0], entrada[0]};
        cout_next = reg_in[WIDTH-1];
      end
      default: begin
        reg_next  = reg_in;
        cout_next = 1'b0;
      end
    endcase
  end

endmodule : reg_op_alu

// File: rtl/banco_registradores.sv
// Register bank derived from the SAP-1 B register: DEPTH registers of WIDTH
// bits, each modified in place (load/inc/dec/shl), with an ULA read port
// (optionally bypassed) and a gated bus read port.
module banco_registradores
  import sap1_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 0
) (
  input  logic                     CLK,
  input  logic                     CLR_n,
  input  logic                     Lb,
  input  logic [1:0]               op,
  input  logic [$clog2(DEPTH)-1:0] sel_esc,
  input  logic [WIDTH-1:0]         entrada,
  input  logic [$clog2(DEPTH)-1:0] sel_ula,
  output logic [WIDTH-1:0]         para_ula,
  input  logic                     Eb,
  input  logic [$clog2(DEPTH)-1:0] sel_bus,
  output logic [WIDTH-1:0]         saida_bus,
  output logic                     valido_ula,
  output logic                     cout,
  output logic                     zero
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic             cout_q;

  logic [WIDTH-1:0] reg_d;
  logic             cout_d;
  logic             bypass_hit_s;

  reg_op_alu #(.WIDTH(WIDTH)) u_reg_op_alu (
    .reg_in    (regs_q[sel_esc]),
    .op        (op),
    .entrada   (entrada),
    .reg_next  (reg_d),
    .cout_next (cout_d)
  );

  // Storage, valid bits and carry flop; only the addressed register changes.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= {WIDTH{1'b0}};
      end
      valid_q <= {DEPTH{1'b0}};
      cout_q  <= 1'b0;
    end else if (Lb) begin
      regs_q[sel_esc]  <= reg_d;
      valid_q[sel_esc] <= 1'b1;
      cout_q           <= cout_d;
    end
  end

  // Forwarding only when a write will really happen at the next edge, so a
  // reset in progress never leaks pending write data onto para_ula.
  assign bypass_hit_s = (BYPASS != 0) && Lb && CLR_n && (sel_ula == sel_esc);

  // Read muxes: ULA port (with optional forwarding) and the gated bus port.
  always_comb begin
    para_ula = regs_q[sel_ula];
    if (bypass_hit_s) begin
      para_ula = reg_d;
    end else begin
      para_ula = regs_q[sel_ula];
    end
    if (Eb) begin
      saida_bus = regs_q[sel_bus];
    end else begin
      saida_bus = {WIDTH{1'b0}};
    end
  end

  assign valido_ula = valid_q[sel_ula];
  assign cout       = cout_q;
  assign zero       = (para_ula == {WIDTH{1'b0}});

endmodule : banco_registradores
